// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation on memory Channel 1,
// a credit-limited prefetch FIFO, a valid/ready drain to decode, and redirect flush.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_rready,
   output logic        ren1,
   output logic [31:0] radd1,
   input  logic [31:0] rdata1,
   input  logic        vrdata1,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          discard;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic [31:0]   mem_data [FIFO_DEPTH];
   logic [CW:0]   occupancy;
   logic          push;
   logic          pop;

   // A request in flight already owns a FIFO slot, so issue is credit-limited
   // on registered state only; decode's inst_ready never reaches ren1.
   assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign ren1       = reset & inst_rready & ~redirect_en & (occupancy < DEPTH_V);
   assign radd1      = fetch_pc;
   assign inst_valid = (count != '0);
   assign push       = reset & vrdata1 & inflight & ~discard & ~redirect_en;
   assign pop        = inst_valid & inst_ready & ~redirect_en;
   assign inst_data  = inst_valid ? mem_data[rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'h0;

   // Stage p0 -> p1: fetch control, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc <= RESET_PC & ~32'd3;
         inflight <= 1'b0;
         discard  <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else if (redirect_en) begin
         fetch_pc <= redirect_pc & ~32'd3;
         inflight <= 1'b0;
         discard  <= inflight;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         discard  <= 1'b0;
         inflight <= ren1;
         if (ren1)
            fetch_pc <= fetch_pc + 32'd4;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Stage p1 -> FIFO: data path, no reset needed since count gates visibility.
   always_ff @(posedge clk) begin
      if (ren1)
         inflight_pc <= fetch_pc;
      if (push) begin
         mem_pc[wr_ptr]   <= inflight_pc;
         mem_data[wr_ptr] <= rdata1;
      end
   end

endmodule
